// File: rtl/bcd_conv_sched.sv
// Shared serial binary-to-BCD converter (double-dabble, one bit per clock)
// fronted by a round-robin arbiter over NREQ requesters.
module bcd_conv_sched #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   bin_in,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 valid,
  output logic [IDW-1:0]       id_out,
  output logic [15:0]          bcd_out,
  output logic                 ovf
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   opnd, opnd_next;
  logic [DW-1:0]   acc, acc_next, acc_adj, acc_sh;
  logic [CW-1:0]   cnt, cnt_next;
  logic [IDW-1:0]  cur_id, cur_id_next;
  logic [IDW-1:0]  last, last_next;
  logic            ovf_pend, ovf_pend_next;
  logic [NREQ-1:0] grant_next;
  logic            busy_next, valid_next, ovf_next;
  logic [IDW-1:0]  id_next;
  logic [DW-1:0]   bcd_next;

  logic [NREQ-1:0] rot;
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [DW-1:0]   win_opnd;

  // Round-robin pick: rotate req so that last+1 sits at bit 0, take lowest set bit.
  always_comb begin
    rot       = NREQ'({req, req} >> (int'(last) + 1));
    win_found = 1'b0;
    win_id    = '0;
    win_opnd  = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!win_found && rot[j]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(last) + 1 + j) % int'(NREQ));
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == win_id) win_opnd = bin_in[i*16 +: 16];
    end
  end

  // Add-3 correction on every digit >= 5, then shift in the next operand bit.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      acc_adj[d*4 +: 4] = (acc[d*4 +: 4] >= 4'd5) ? 4'(acc[d*4 +: 4] + 4'd3)
                                                 : acc[d*4 +: 4];
    end
    acc_sh = DW'({acc_adj, opnd[DW-1]});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found)      state_next = SHIFT;
      SHIFT:   if (cnt == '0)      state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    opnd_next     = opnd;
    acc_next      = acc;
    cnt_next      = cnt;
    cur_id_next   = cur_id;
    last_next     = last;
    ovf_pend_next = ovf_pend;
    grant_next    = '0;
    valid_next    = 1'b0;
    busy_next     = busy;
    bcd_next      = bcd_out;
    ovf_next      = ovf;
    id_next       = id_out;
    case (state)
      IDLE: begin
        if (win_found) begin
          opnd_next     = win_opnd;
          acc_next      = '0;
          cnt_next      = CW'(15);
          cur_id_next   = win_id;
          last_next     = win_id;
          ovf_pend_next = (win_opnd >= 16'd10000);
          grant_next    = NREQ'(1) << win_id;
          busy_next     = 1'b1;
        end
      end
      SHIFT: begin
        acc_next  = acc_sh;
        opnd_next = opnd << 1;
        cnt_next  = cnt - CW'(1);
        if (cnt == '0) begin
          bcd_next   = acc_sh;
          ovf_next   = ovf_pend;
          id_next    = cur_id;
          valid_next = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      cur_id   <= '0;
      last     <= IDW'(NREQ - 1);
      ovf_pend <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
      id_out   <= '0;
    end else begin
      opnd     <= opnd_next;
      acc      <= acc_next;
      cnt      <= cnt_next;
      cur_id   <= cur_id_next;
      last     <= last_next;
      ovf_pend <= ovf_pend_next;
      grant    <= grant_next;
      busy     <= busy_next;
      valid    <= valid_next;
      bcd_out  <= bcd_next;
      ovf      <= ovf_next;
      id_out   <= id_next;
    end
  end

endmodule
